// File: rtl/sc_period_meter_if.sv
// sc_period_meter_if
//   Signal bundle between a period-meter client and sc_period_meter.
//   Members:
//     SC_PERIODMETER_ENABLE_InHigh  measurement enable (client -> meter)
//     SC_PERIODMETER_SIGNAL_In      asynchronous signal under measurement (client -> meter)
//     SC_PERIODMETER_PERIOD_Out     last measured period in cycles (meter -> client)
//     SC_PERIODMETER_HIGH_Out       last measured high time in cycles (meter -> client)
//     SC_PERIODMETER_VALID_Out      one-cycle strobe, PERIOD/HIGH updated (meter -> client)
//     SC_PERIODMETER_RISE_Out       one-cycle strobe per detected rising edge (meter -> client)
//     SC_PERIODMETER_TIMEOUT_Out    loss-of-signal level (meter -> client)
//   Modports: master (client side), slave (meter side).
interface sc_period_meter_if #(
    parameter int CNT_WIDTH = 28
);
    logic                 SC_PERIODMETER_ENABLE_InHigh;
    logic                 SC_PERIODMETER_SIGNAL_In;
    logic [CNT_WIDTH-1:0] SC_PERIODMETER_PERIOD_Out;
    logic [CNT_WIDTH-1:0] SC_PERIODMETER_HIGH_Out;
    logic                 SC_PERIODMETER_VALID_Out;
    logic                 SC_PERIODMETER_RISE_Out;
    logic                 SC_PERIODMETER_TIMEOUT_Out;

    modport master (
        output SC_PERIODMETER_ENABLE_InHigh,
        output SC_PERIODMETER_SIGNAL_In,
        input  SC_PERIODMETER_PERIOD_Out,
        input  SC_PERIODMETER_HIGH_Out,
        input  SC_PERIODMETER_VALID_Out,
        input  SC_PERIODMETER_RISE_Out,
        input  SC_PERIODMETER_TIMEOUT_Out
    );

    modport slave (
        input  SC_PERIODMETER_ENABLE_InHigh,
        input  SC_PERIODMETER_SIGNAL_In,
        output SC_PERIODMETER_PERIOD_Out,
        output SC_PERIODMETER_HIGH_Out,
        output SC_PERIODMETER_VALID_Out,
        output SC_PERIODMETER_RISE_Out,
        output SC_PERIODMETER_TIMEOUT_Out
    );
endinterface

// File: rtl/sc_period_meter.sv
// sc_period_meter
//   Measures period and high time (in SC_PERIODMETER_CLOCK_50 cycles) of a
//   slow asynchronous square wave, publishes each result with a one-cycle
//   VALID strobe, and flags loss of signal after TIMEOUT cycles without a
//   rising edge.
//   Ports:
//     SC_PERIODMETER_CLOCK_50      system clock
//     SC_PERIODMETER_RESET_InHigh  synchronous active-high reset
//     pm                           sc_period_meter_if.slave (enable, signal, results)
module sc_period_meter #(
    parameter int                   CNT_WIDTH = 28,
    parameter logic [CNT_WIDTH-1:0] TIMEOUT   = CNT_WIDTH'(100000000)
) (
    input  logic                 SC_PERIODMETER_CLOCK_50,
    input  logic                 SC_PERIODMETER_RESET_InHigh,
    sc_period_meter_if.slave     pm
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        LOST    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 s1, s2, s3;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] high_q, high_d;
    logic                 valid_q, valid_d;
    logic                 timeout_q, timeout_d;
    logic                 rise_q;
    logic                 rise_evt, fall_evt;

    assign rise_evt = s2 & ~s3;
    assign fall_evt = ~s2 & s3;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        if (!pm.SC_PERIODMETER_ENABLE_InHigh) begin
            state_d   = IDLE;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    state_d   = ARM;
                end
                ARM: begin
                    // First edge only starts the count; nothing is reported.
                    if (rise_evt) begin
                        cnt_d   = CNT_WIDTH'(1);
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (fall_evt) begin
                        high_d = cnt_q;
                    end
                    // A rise on the very cycle the counter hits TIMEOUT is a
                    // valid period, so it is tested before the timeout.
                    if (rise_evt) begin
                        period_d = cnt_q;
                        valid_d  = 1'b1;
                        cnt_d    = CNT_WIDTH'(1);
                    end else if (cnt_q == TIMEOUT) begin
                        state_d   = LOST;
                        timeout_d = 1'b1;
                        period_d  = '0;
                        high_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                LOST: begin
                    period_d  = '0;
                    high_d    = '0;
                    timeout_d = 1'b1;
                    if (rise_evt) begin
                        timeout_d = 1'b0;
                        cnt_d     = CNT_WIDTH'(1);
                        state_d   = MEASURE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge SC_PERIODMETER_CLOCK_50) begin
        if (SC_PERIODMETER_RESET_InHigh) begin
            state_q   <= IDLE;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            cnt_q     <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1        <= pm.SC_PERIODMETER_SIGNAL_In;
            s2        <= s1;
            s3        <= s2;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            rise_q    <= rise_evt;
        end
    end

    assign pm.SC_PERIODMETER_PERIOD_Out  = period_q;
    assign pm.SC_PERIODMETER_HIGH_Out    = high_q;
    assign pm.SC_PERIODMETER_VALID_Out   = valid_q;
    assign pm.SC_PERIODMETER_RISE_Out    = rise_q;
    assign pm.SC_PERIODMETER_TIMEOUT_Out = timeout_q;

endmodule
